// File: rtl/add_arbiter.sv
// add_arbiter: round-robin arbiter that lets NREQ requesters share a single
// carry-lookahead adder. Each accepted operand pair produces one registered
// sum in a single-entry output slot, tagged with the requester index.

// ---------------------------------------------------------------------------
// 4-bit-group carry-lookahead adder. Carries ripple between groups and are
// looked ahead inside each group. Carry-out is intentionally not produced.
// ---------------------------------------------------------------------------
module add_arbiter_cla #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum
);
  localparam int NGRP = WIDTH / 4;

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_c;       // carry into each bit
  logic [NGRP-1:0]  w_grp_g;
  logic [NGRP-1:0]  w_grp_p;
  logic [NGRP-1:0]  w_grp_c;   // carry into each 4-bit group

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Group generate / propagate for every 4-bit slice.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_grp_g = '0;
    w_grp_p = '0;
    for (int k = 0; k < NGRP; k++) begin
      w_grp_g[k] = w_g[4*k+3]
                 | (w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      w_grp_p[k] = &w_p[4*k +: 4];
    end
  end

  // Group-level carry chain; a local running carry avoids a self-referencing vector.
  always_comb begin
    logic carry;
    // NOTE: blocking assignments here model combinational flow; only clocked state uses <=.
    carry   = 1'b0;
    w_grp_c = '0;
    for (int k = 0; k < NGRP; k++) begin
      w_grp_c[k] = carry;
      carry      = w_grp_g[k] | (w_grp_p[k] & carry);
    end
  end

  // Lookahead carries inside each group from that group's carry-in.
  always_comb begin
    w_c = '0;
    for (int k = 0; k < NGRP; k++) begin
      w_c[4*k]   = w_grp_c[k];
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_grp_c[k]);
      w_c[4*k+2] = w_g[4*k+1]
                 | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_grp_c[k]);
      w_c[4*k+3] = w_g[4*k+2]
                 | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_grp_c[k]);
    end
  end

  assign o_sum = w_p ^ w_c;
endmodule

// ---------------------------------------------------------------------------
// Top: round-robin grant, operand mux, shared adder, single-entry result slot.
// ---------------------------------------------------------------------------
module add_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic [1:0]            rsp_id,
  output logic [15:0]           txn_cnt
);
  localparam int IDW = 2;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [WIDTH-1:0] r_sum;
  logic [IDW-1:0]   r_id;
  logic [15:0]      r_cnt;

  logic             w_slot_free;
  logic             w_grant_vld;
  logic [IDW-1:0]   w_grant_id;
  logic             w_xfer;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;

  // The slot can take a new result when empty or being drained this cycle;
  // holding reset blocks every grant.
  assign w_slot_free = rst_n & ((r_state == S_EMPTY) | rsp_ready);

  // First valid requester searching from the priority pointer, wrapping mod NREQ.
  always_comb begin
    logic [IDW-1:0] idx;
    idx         = '0;
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = r_ptr + IDW'(k);
      if (!w_grant_vld && req_valid[idx]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = idx;
      end
    end
  end

  assign w_xfer    = w_slot_free & w_grant_vld;
  assign req_ready = w_xfer ? (NREQ'(1) << w_grant_id) : '0;

  // Route the granted requester's operands into the shared adder.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_id == IDW'(i)) begin
        w_a = req_a[i*WIDTH +: WIDTH];
        w_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  add_arbiter_cla #(.WIDTH(WIDTH)) u_cla (
    .i_a   (w_a),
    .i_b   (w_b),
    .o_sum (w_sum)
  );

  // Slot state machine with registered result, tag, priority pointer and counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_ptr   <= '0;
      r_sum   <= '0;
      r_id    <= '0;
      r_cnt   <= '0;
    end else if (w_xfer) begin
      r_state <= S_FULL;
      r_sum   <= w_sum;
      r_id    <= w_grant_id;
      r_ptr   <= w_grant_id + IDW'(1);
      r_cnt   <= r_cnt + 16'd1;
    end else if ((r_state == S_FULL) && rsp_ready) begin
      r_state <= S_EMPTY;
    end
  end

  assign rsp_valid = (r_state == S_FULL);
  assign rsp_sum   = r_sum;
  assign rsp_id    = r_id;
  assign txn_cnt   = r_cnt;
endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed stimulus for add_arbiter, checked every cycle
// against a transaction-level model (result queue + modular arithmetic) and
// at key points against hand-computed literal values.
module tb_add_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic [1:0]            rsp_id;
  logic [15:0]           txn_cnt;

  add_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .txn_cnt   (txn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic [31:0] sum;
    int          id;
  } rsp_t;

  rsp_t        m_q[$];        // contents of the output slot (at most one entry)
  int          m_ptr;         // requester with highest priority
  int          m_cnt;         // accepted requests mod 2^16
  logic [31:0] m_last_sum;
  int          m_last_id;
  bit          chk_en = 1'b0;

  function automatic int model_grant();
    if (!rst_n) return -1;
    if (m_q.size() != 0 && !rsp_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    if (!rst_n) begin
      m_q.delete();
      m_ptr      = 0;
      m_cnt      = 0;
      m_last_sum = '0;
      m_last_id  = 0;
    end else begin
      g = model_grant();
      if (m_q.size() != 0 && rsp_ready) void'(m_q.pop_front());
      if (g >= 0) begin
        rsp_t r;
        longint full;
        full  = longint'(req_a[g*WIDTH +: WIDTH]) + longint'(req_b[g*WIDTH +: WIDTH]);
        r.sum = full[31:0];
        r.id  = g;
        m_q.push_back(r);
        m_last_sum = r.sum;
        m_last_id  = g;
        m_ptr      = (g + 1) % NREQ;
        m_cnt      = (m_cnt + 1) % 65536;
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      int g;
      g = model_grant();
      check("req_ready", 64'(req_ready), (g >= 0) ? 64'(1 << g) : 64'd0);
      check("rsp_valid", 64'(rsp_valid), 64'(m_q.size() != 0));
      check("rsp_sum",   64'(rsp_sum),   64'(m_last_sum));
      check("rsp_id",    64'(rsp_id),    64'(m_last_id));
      check("txn_cnt",   64'(txn_cnt),   64'(m_cnt));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  logic [3:0]  rr_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0]  rr_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [31:0] rr_sum [5] = '{32'h10, 32'h21, 32'h32, 32'h43, 32'h10};

  // Directed {req_valid, rsp_ready} sequence mixing stalls, drains and drops.
  logic [4:0] vec [16] = '{5'b0011_1, 5'b0011_0, 5'b0000_0, 5'b1000_1,
                           5'b0100_1, 5'b0000_1, 5'b0000_1, 5'b1111_0,
                           5'b1111_0, 5'b0010_1, 5'b1001_1, 5'b1001_1,
                           5'b0110_0, 5'b0000_1, 5'b1111_1, 5'b0101_1};

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;

    // Reset state; requests are ignored while reset is held.
    tick();
    chk_en = 1'b1;
    check("reset req_ready", 64'(req_ready), 64'h0);
    tick();
    check("reset rsp_valid", 64'(rsp_valid), 64'h0);
    check("reset rsp_sum",   64'(rsp_sum),   64'h0);
    check("reset txn_cnt",   64'(txn_cnt),   64'h0);

    // Single transfer: 5 + 7.
    rst_n     = 1'b1;
    req_valid = 4'b0001;
    set_op(0, 32'h5, 32'h7);
    #1 check("single req_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0000;
    check("single rsp_valid", 64'(rsp_valid), 64'h1);
    check("single rsp_sum",   64'(rsp_sum),   64'hC);
    check("single rsp_id",    64'(rsp_id),    64'h0);
    check("single txn_cnt",   64'(txn_cnt),   64'h1);

    // Carry chains: full wrap and a 16-bit ripple.
    set_op(2, 32'hFFFF_FFFF, 32'h1);
    set_op(3, 32'h0000_FFFF, 32'h1);
    req_valid = 4'b0100;
    tick();
    check("wrap sum", 64'(rsp_sum), 64'h0);
    check("wrap id",  64'(rsp_id),  64'h2);
    req_valid = 4'b1000;
    tick();
    check("carry16 sum", 64'(rsp_sum), 64'h0001_0000);
    check("carry16 id",  64'(rsp_id),  64'h3);
    req_valid = 4'b0000;
    tick();
    check("drain rsp_valid", 64'(rsp_valid), 64'h0);
    check("drain sum held",  64'(rsp_sum),   64'h0001_0000);

    // Round-robin from reset with all four requesting.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(16 * (i + 1)), 32'(i));
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 check("rr req_ready", 64'(req_ready), 64'(rr_gnt[k]));
      tick();
      check("rr rsp_valid", 64'(rsp_valid), 64'h1);
      check("rr rsp_id",    64'(rsp_id),    64'(rr_id[k]));
      check("rr rsp_sum",   64'(rsp_sum),   64'(rr_sum[k]));
    end

    // Backpressure: slot holds requester 0's result, nothing granted.
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check("bp req_ready", 64'(req_ready), 64'h0);
      check("bp rsp_sum", 64'(rsp_sum), 64'h10);
      check("bp rsp_id",  64'(rsp_id),  64'h0);
      tick();
    end
    rsp_ready = 1'b1;
    #1 check("bp release grant", 64'(req_ready), 64'b0010);
    tick();
    check("bp release id",  64'(rsp_id),  64'h1);
    check("bp release sum", 64'(rsp_sum), 64'h21);

    // Idle cycles must not rotate priority (pointer stays at 2).
    req_valid = 4'b0000;
    tick();
    tick();
    req_valid = 4'b1010;
    #1 check("idle ptr grant", 64'(req_ready), 64'b1000);
    tick();
    check("idle ptr id", 64'(rsp_id), 64'h3);

    // Reset while a result is held.
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    tick();
    rst_n = 1'b0;
    #1 check("midrst req_ready", 64'(req_ready), 64'h0);
    tick();
    check("midrst rsp_valid", 64'(rsp_valid), 64'h0);
    check("midrst rsp_sum",   64'(rsp_sum),   64'h0);
    check("midrst txn_cnt",   64'(txn_cnt),   64'h0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0110;
    #1 check("midrst first grant", 64'(req_ready), 64'b0010);
    tick();
    check("midrst first id", 64'(rsp_id),  64'h1);
    check("midrst txn_cnt1", 64'(txn_cnt), 64'h1);

    // Directed mix, checked by the model each cycle.
    for (int k = 0; k < 16; k++) begin
      req_valid = vec[k][4:1];
      rsp_ready = vec[k][0];
      set_op(k % NREQ, 32'h1234_0000 + 32'(k), 32'hFFFF_0000 - 32'(k * 3));
      tick();
    end

    // Counter wrap after 65536 transfers from reset.
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    set_op(0, 32'h5, 32'h7);
    repeat (65535) tick();
    check("cnt max", 64'(txn_cnt), 64'hFFFF);
    tick();
    req_valid = 4'b0000;
    check("cnt wrap", 64'(txn_cnt), 64'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
